fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-side front end of the asynchronous FIFO, directly upstream of the write-pointer/full stage. It accepts producer words on a valid/ready handshake and holds them in a 2-entry skid buffer, so the producer-facing ready is registered. It issues winc/wdata into the FIFO only while wfull is low. It also derives a registered fill level and almost-full flag from the Gray write pointer and the synchronised Gray read pointer.

Parameters:
DSIZE, 8, data word width
ADDRSIZE, 4, FIFO address width; depth = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits Gray
AFULL_THRESH, 2, wafull asserts when free slots <= AFULL_THRESH (legal range 0..2**ADDRSIZE-1)

Ports:
wclk  in  1  write-domain clock; all logic on rising edge
wrst  in  1  asynchronous active-high reset
s_valid  in  1  producer word valid
s_data  in  DSIZE  producer word
s_ready  out  1  registered; producer may present a word
wfull  in  1  registered full flag from the write-pointer stage
wptr  in  ADDRSIZE+1  Gray write pointer from the write-pointer stage
wq2_rptr  in  ADDRSIZE+1  Gray read pointer, already 2-flop synchronised into wclk
winc  out  1  FIFO write strobe (combinational)
wdata  out  DSIZE  FIFO write data, valid while winc=1
wlevel  out  ADDRSIZE+1  registered FIFO occupancy, 0..2**ADDRSIZE
wafull  out  1  registered almost-full flag

Behaviour:
- Reset (async assert, sync release): skid empty; s_ready=0; winc=0; wdata=0; wlevel=0; wafull=0. The first rising edge after release sets s_ready=1.
- Skid FSM on occupancy: EMPTY, ONE, TWO.
  - push = s_valid & s_ready.
  - pop = winc.
  - occ_next = occ + push - pop.
  - Transitions: EMPTY->ONE on push; ONE->TWO on push & ~pop; ONE->EMPTY on pop & ~push; TWO->ONE on pop. Push & pop in ONE stays in ONE.
  - TWO with no pop holds. Push while in TWO cannot occur, because s_ready=0.
- s_ready <= (occ_next != TWO). Ready therefore drops the cycle after the second entry fills and rises the cycle after a pop from TWO.
- winc = (occ != EMPTY) & ~wfull.
- wdata = head entry (oldest word).
- Ordering is strict FIFO:
  - A push into EMPTY becomes head.
  - A push alongside a pop in ONE replaces head.
  - A pop from TWO promotes tail to head.
- Word latency from s_valid&s_ready to winc is 1 cycle when wfull=0.
- wfull=1: winc held 0 and entries held; the skid fills to TWO and then s_ready falls. No word is ever dropped or duplicated.
- Level computation:
  - Convert wptr and wq2_rptr Gray->binary.
  - Compute diff = wbin - rbin, modulo 2**(ADDRSIZE+1) (wrap-around is natural).
  - Register wlevel <= diff.
  - Register wafull <= ((2**ADDRSIZE - diff) <= AFULL_THRESH).
  - The level is therefore 1 cycle behind wptr. It is conservative (over-estimates occupancy) because of the read-pointer sync lag.
- wafull is advisory only; gating is by wfull alone.
- Reset mid-operation: skid contents are discarded immediately; all outputs go to their reset values asynchronously.

Decomposition:
- Package fifo_pkg:
  - skid occupancy enum typedef (EMPTY/ONE/TWO);
  - function gray2bin (parameterised width, XOR-prefix);
  - localparam DEPTH = 1<<ADDRSIZE.
- One sub-module, fifo_skid2: 2-entry skid buffer with push/pop/head/occ and registered ready.
- fifo_wr_ctrl instantiates fifo_skid2 and holds the level/almost-full logic.

Test Plan:
- Reset, then s_valid=1 with data 0x01,0x02,0x03 and wfull=0 -> s_ready=1 one cycle after release; winc pulses carry wdata 0x01,0x02,0x03 in order, each 1 cycle after acceptance.
- Hold wfull=1, push 0xA0,0xA1,0xA2 -> 0xA0,0xA1 accepted; s_ready=0 the cycle after 0xA1; winc=0. Release wfull -> winc emits 0xA0 then 0xA1; s_ready returns 1; 0xA2 is then accepted.
- Drive wptr=gray(13), wq2_rptr=gray(0) -> next cycle wlevel=13, wafull=0. Then wptr=gray(14) -> wlevel=14, wafull=1.
- Wrap case: wptr=gray(3), wq2_rptr=gray(30) (5-bit) -> wlevel=5, wafull=0.
- Full case: wptr=gray(16), wq2_rptr=gray(0) -> wlevel=16, wafull=1.
- Skid at TWO, assert wrst for 1 cycle -> immediately s_ready=0, winc=0, wlevel=0, wafull=0. After release, the first pushed word (0x55) is the first word written; no stale words.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the FIFO write-side front end.
package fifo_pkg;

  localparam int FIFO_ADDRSIZE = 4;
  localparam int DEPTH         = 1 << FIFO_ADDRSIZE;
  localparam int GRAY_MAX_W    = 32;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_occ_e;

  // Works for any pointer up to GRAY_MAX_W bits: zero-extend on the way in,
  // truncate on the way out.
  function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] g);
    logic [GRAY_MAX_W-1:0] b;
    b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
    for (int i = GRAY_MAX_W-2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wr_ctrl_if.sv
// Producer handshake, FIFO write port and pointer/level signals of the write front end.
interface fifo_wr_ctrl_if #(
  parameter int DSIZE    = 8,
  parameter int ADDRSIZE = fifo_pkg::FIFO_ADDRSIZE
);
  logic                s_valid;
  logic [DSIZE-1:0]    s_data;
  logic                s_ready;
  logic                wfull;
  logic [ADDRSIZE:0]   wptr;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic                winc;
  logic [DSIZE-1:0]    wdata;
  logic [ADDRSIZE:0]   wlevel;
  logic                wafull;

  modport master (
    output s_valid, s_data, wfull, wptr, wq2_rptr,
    input  s_ready, winc, wdata, wlevel, wafull
  );

  modport slave (
    input  s_valid, s_data, wfull, wptr, wq2_rptr,
    output s_ready, winc, wdata, wlevel, wafull
  );
endinterface

// File: rtl/fifo_skid2.sv
// Two-entry skid buffer with registered ready; head is always the oldest word.
// state | meaning
// EMPTY | no words held
// ONE   | head valid
// TWO   | head and tail valid, ready low
module fifo_skid2
  import fifo_pkg::*;
#(
  parameter int DSIZE = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_valid_i,
  input  logic [DSIZE-1:0] push_data_i,
  input  logic             pop_i,
  output logic             push_ready_o,
  output logic [DSIZE-1:0] head_o,
  output skid_occ_e        occ_o
);

  skid_occ_e        occ_q, occ_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] tail_q, tail_d;
  logic             ready_q, ready_d;
  logic             push;

  assign push = push_valid_i & ready_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ_q   <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      ready_q <= ready_d;
    end
  end

  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      EMPTY: begin
        if (push) begin
          head_d = push_data_i;
          occ_d  = ONE;
        end
      end
      ONE: begin
        if (push && pop_i) begin
          head_d = push_data_i;
        end else if (push) begin
          tail_d = push_data_i;
          occ_d  = TWO;
        end else if (pop_i) begin
          occ_d = EMPTY;
        end
      end
      TWO: begin
        if (pop_i) begin
          head_d = tail_q;
          occ_d  = ONE;
        end
      end
      default: occ_d = EMPTY;
    endcase
    ready_d = (occ_d != TWO);
  end

  assign push_ready_o = ready_q;
  assign head_o       = head_q;
  assign occ_o        = occ_q;

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side front end: skid-buffered producer port, wfull-gated write strobe,
// and registered fill level / almost-full derived from the Gray pointers.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DSIZE        = 8,
  parameter int ADDRSIZE     = FIFO_ADDRSIZE,
  parameter int AFULL_THRESH = 2
) (
  input logic           wclk,
  input logic           wrst,
  fifo_wr_ctrl_if.slave bus
);

  localparam int            PW       = ADDRSIZE + 1;
  localparam logic [PW-1:0] DEPTH_P  = PW'(1 << ADDRSIZE);
  localparam logic [PW-1:0] THRESH_P = PW'(AFULL_THRESH);

  skid_occ_e        occ;
  logic [DSIZE-1:0] head;
  logic             s_ready;
  logic             winc;

  assign winc = (occ != EMPTY) & ~bus.wfull;

  fifo_skid2 #(.DSIZE(DSIZE)) u_skid (
    .clk_i        (wclk),
    .rst_i        (wrst),
    .push_valid_i (bus.s_valid),
    .push_data_i  (bus.s_data),
    .pop_i        (winc),
    .push_ready_o (s_ready),
    .head_o       (head),
    .occ_o        (occ)
  );

  assign bus.s_ready = s_ready;
  assign bus.winc    = winc;
  assign bus.wdata   = head;

  logic [PW-1:0] wbin, rbin, diff, free_slots;
  logic [PW-1:0] wlevel_q, wlevel_d;
  logic          wafull_q, wafull_d;

  // Modular subtraction handles pointer wrap without special casing.
  assign wbin       = PW'(gray2bin(GRAY_MAX_W'(bus.wptr)));
  assign rbin       = PW'(gray2bin(GRAY_MAX_W'(bus.wq2_rptr)));
  assign diff       = wbin - rbin;
  assign free_slots = DEPTH_P - diff;
  assign wlevel_d   = diff;
  assign wafull_d   = (free_slots <= THRESH_P);

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wlevel_q <= '0;
      wafull_q <= 1'b0;
    end else begin
      wlevel_q <= wlevel_d;
      wafull_q <= wafull_d;
    end
  end

  assign bus.wlevel = wlevel_q;
  assign bus.wafull = wafull_q;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl: scoreboarded data path plus level/almost-full table.
module tb_fifo_wr_ctrl;

  localparam int DSIZE    = 8;
  localparam int ADDRSIZE = 4;
  localparam int PW       = ADDRSIZE + 1;

  logic wclk = 1'b0;
  logic wrst;

  always #5 wclk = ~wclk;

  fifo_wr_ctrl_if #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE)) bus ();

  fifo_wr_ctrl #(.DSIZE(DSIZE), .ADDRSIZE(ADDRSIZE), .AFULL_THRESH(2)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [DSIZE-1:0] sb[$];

  typedef struct {
    int w;
    int r;
    int lvl;
    int af;
  } lvl_vec_t;

  lvl_vec_t lv[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [PW-1:0] gray(input int b);
    logic [PW-1:0] x;
    x = PW'(b);
    return x ^ (x >> 1);
  endfunction

  // Scoreboard: words accepted on the producer side must reappear on winc in order.
  always @(negedge wclk) begin
    if (wrst === 1'b0) begin
      if (bus.winc === 1'b1) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_write: got 0x%0h expected no write", bus.wdata);
        end else begin
          check("wdata_order", 32'(bus.wdata), 32'(sb.pop_front()));
        end
      end
      if (bus.s_valid && bus.s_ready) sb.push_back(bus.s_data);
    end
  end

  task automatic send(input logic [DSIZE-1:0] d, input int budget);
    int n;
    n = 0;
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    while (n < budget) begin
      @(negedge wclk);
      if (bus.s_ready) break;
      n++;
    end
    if (n >= budget) begin
      n_total++;
      $display("FAIL send_timeout: data 0x%0h not accepted within %0d cycles", d, budget);
    end
    @(posedge wclk);
    #1;
    bus.s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    lv[0] = '{13, 0, 13, 0};
    lv[1] = '{14, 0, 14, 1};
    lv[2] = '{3, 30, 5, 0};
    lv[3] = '{16, 0, 16, 1};
    lv[4] = '{0, 0, 0, 0};
    lv[5] = '{31, 20, 11, 0};
    lv[6] = '{2, 20, 14, 1};
    lv[7] = '{15, 0, 15, 1};
    lv[8] = '{20, 10, 10, 0};
    lv[9] = '{7, 7, 0, 0};

    wrst         = 1'b1;
    bus.s_valid  = 1'b0;
    bus.s_data   = '0;
    bus.wfull    = 1'b0;
    bus.wptr     = '0;
    bus.wq2_rptr = '0;

    repeat (3) @(posedge wclk);
    #1;
    check("rst_s_ready", 32'(bus.s_ready), 0);
    check("rst_winc",    32'(bus.winc),    0);
    check("rst_wdata",   32'(bus.wdata),   0);
    check("rst_wlevel",  32'(bus.wlevel),  0);
    check("rst_wafull",  32'(bus.wafull),  0);
    wrst = 1'b0;
    #1;
    check("rel_s_ready_low", 32'(bus.s_ready), 0);
    @(posedge wclk);
    #1;
    check("rel_s_ready_high", 32'(bus.s_ready), 1);

    // Streaming: each word appears on winc one cycle after acceptance.
    for (int i = 1; i <= 3; i++) begin
      send(DSIZE'(i), 20);
      check("lat_winc",  32'(bus.winc),  1);
      check("lat_wdata", 32'(bus.wdata), 32'(i));
    end
    repeat (3) @(posedge wclk);
    #1;

    // Backpressure from wfull fills the skid, then drains in order.
    bus.wfull = 1'b1;
    send(8'hA0, 20);
    check("full_winc0", 32'(bus.winc), 0);
    send(8'hA1, 20);
    check("full_s_ready", 32'(bus.s_ready), 0);
    check("full_winc1",   32'(bus.winc),    0);
    bus.s_valid = 1'b1;
    bus.s_data  = 8'hA2;
    repeat (3) @(posedge wclk);
    #1;
    check("full_hold_ready", 32'(bus.s_ready), 0);
    check("full_hold_winc",  32'(bus.winc),    0);
    bus.wfull = 1'b0;
    #1;
    check("drain_winc",  32'(bus.winc),  1);
    check("drain_wdata", 32'(bus.wdata), 32'hA0);
    send(8'hA2, 20);
    check("drain_a2_wdata", 32'(bus.wdata), 32'hA2);
    repeat (3) @(posedge wclk);
    #1;

    // Level / almost-full table; level lags pointers by one cycle.
    for (int i = 0; i < 10; i++) begin
      bus.wptr     = gray(lv[i].w);
      bus.wq2_rptr = gray(lv[i].r);
      #1;
      if (i > 0) check("wlevel_lag", 32'(bus.wlevel), 32'(lv[i-1].lvl));
      @(posedge wclk);
      #1;
      check($sformatf("wlevel[%0d]", i), 32'(bus.wlevel), 32'(lv[i].lvl));
      check($sformatf("wafull[%0d]", i), 32'(bus.wafull), 32'(lv[i].af));
    end

    // Reset with the skid full discards both words.
    bus.wptr     = gray(14);
    bus.wq2_rptr = gray(0);
    bus.wfull    = 1'b1;
    send(8'hB0, 20);
    send(8'hB1, 20);
    @(posedge wclk);
    #1;
    check("pre_rst_ready",  32'(bus.s_ready), 0);
    check("pre_rst_wafull", 32'(bus.wafull),  1);
    wrst      = 1'b1;
    bus.wfull = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_s_ready", 32'(bus.s_ready), 0);
    check("mid_rst_winc",    32'(bus.winc),    0);
    check("mid_rst_wlevel",  32'(bus.wlevel),  0);
    check("mid_rst_wafull",  32'(bus.wafull),  0);
    @(posedge wclk);
    #1;
    bus.wptr     = '0;
    bus.wq2_rptr = '0;
    wrst         = 1'b0;
    @(posedge wclk);
    #1;
    check("post_rst_ready", 32'(bus.s_ready), 1);
    send(8'h55, 20);
    check("post_rst_winc",  32'(bus.winc),  1);
    check("post_rst_wdata", 32'(bus.wdata), 32'h55);

    repeat (4) @(posedge wclk);
    #1;
    check("sb_empty", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
